pkt_tx_framer: RTL and testbench

TX framing stage directly upstream of the NoC packet processor. Takes raw flit-data beats plus per-packet VC and size from the AXI slave write path, and tracks packet position with an FSM and down-counter. Drives a registered request (valid, req_new, req_last, data, pkt_sz, vc_id) matching the pkt_out_req fields consumed by the packet processor. Owns the head/body/tail framing decision so the combinational processor only encodes it.

---
 rtl/ravenoc_pkg.sv | 23 ++
 rtl/pkt_tx_out_reg.sv | 44 ++++
 rtl/pkt_tx_framer.sv | 123 ++++++++++++
 tb/tb_pkt_tx_framer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// Shared NoC types and widths for the TX framing path.
// Optional VC-consistency checking in pkt_tx_framer is enabled by defining FRAMER_VC_CHECK_EN.
package ravenoc_pkg;
    localparam int FlitDataWidth = 32;
    localparam int NumVirtChn    = 2;
    localparam int PktWidth      = 8;
    localparam int VcWidth       = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1;

    typedef enum logic {
        FR_IDLE,
        FR_IN_PKT
    } framer_st_t;

    // Field order matches the framer outputs so a wrapper can pack them directly.
    typedef struct packed {
        logic                     valid;
        logic                     req_new;
        logic                     req_last;
        logic [FlitDataWidth-1:0] flit_data_width;
        logic [PktWidth-1:0]      pkt_sz;
        logic [VcWidth-1:0]       vc_id;
    } s_pkt_out_req_t;
endpackage

// File: rtl/pkt_tx_out_reg.sv
// One-slot ready/valid register slice; a drain and a new load in the same cycle
// overwrite the slot without a bubble.
module pkt_tx_out_reg #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);
    logic             valid_q, valid_d;
    logic [Width-1:0] data_q, data_d;
    logic             load;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign load        = in_valid_i && in_ready_o;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/pkt_tx_framer.sv
// TX framer: tags AXI write beats as head/body/tail and registers the request
// toward the packet processor. Define FRAMER_VC_CHECK_EN for the sticky VC-mismatch flag.
module pkt_tx_framer
    import ravenoc_pkg::*;
#(
    parameter int FlitDataWidth = ravenoc_pkg::FlitDataWidth,
    parameter int NumVirtChn    = ravenoc_pkg::NumVirtChn,
    parameter int PktWidth      = ravenoc_pkg::PktWidth
) (
    input  logic                                         clk_axi,
    input  logic                                         arst_axi,
    input  logic                                         wr_valid_i,
    output logic                                         wr_ready_o,
    input  logic [FlitDataWidth-1:0]                     wr_data_i,
    input  logic [((NumVirtChn>1)?$clog2(NumVirtChn):1)-1:0] wr_vc_i,
    input  logic [PktWidth-1:0]                          wr_pkt_sz_i,
    output logic                                         pkt_valid_o,
    input  logic                                         pkt_ready_i,
    output logic                                         pkt_req_new_o,
    output logic                                         pkt_req_last_o,
    output logic [FlitDataWidth-1:0]                     pkt_data_o,
    output logic [PktWidth-1:0]                          pkt_sz_o,
    output logic [((NumVirtChn>1)?$clog2(NumVirtChn):1)-1:0] pkt_vc_o,
    output logic                                         busy_o,
    output logic                                         err_o
);
    localparam int VcWidth = (NumVirtChn > 1) ? $clog2(NumVirtChn) : 1;
    localparam int OutW    = 2 + FlitDataWidth + PktWidth + VcWidth;

    framer_st_t          state_q, state_d;
    logic [PktWidth-1:0] rem_q, rem_d;
    logic [PktWidth-1:0] sz_q, sz_d;
    logic [VcWidth-1:0]  vc_q, vc_d;
    logic                accept;
    logic                req_new_d, req_last_d;
    logic [PktWidth-1:0] out_sz_d;
    logic [VcWidth-1:0]  out_vc_d;
    logic [OutW-1:0]     out_payload;

    assign accept = wr_valid_i && wr_ready_o;
    assign busy_o = (state_q == FR_IN_PKT);

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        sz_d       = sz_q;
        vc_d       = vc_q;
        req_new_d  = 1'b0;
        req_last_d = 1'b0;
        out_sz_d   = sz_q;
        out_vc_d   = vc_q;
        case (state_q)
            FR_IDLE: begin
                req_new_d  = 1'b1;
                req_last_d = (wr_pkt_sz_i == '0);
                out_sz_d   = wr_pkt_sz_i;
                out_vc_d   = wr_vc_i;
                if (accept && (wr_pkt_sz_i != '0)) begin
                    rem_d   = wr_pkt_sz_i;
                    sz_d    = wr_pkt_sz_i;
                    vc_d    = wr_vc_i;
                    state_d = FR_IN_PKT;
                end
            end
            FR_IN_PKT: begin
                req_last_d = (rem_q == PktWidth'(1));
                if (accept) begin
                    // Saturating decrement: the counter can never wrap below zero.
                    if (rem_q != '0) rem_d = rem_q - PktWidth'(1);
                    if (rem_q <= PktWidth'(1)) state_d = FR_IDLE;
                end
            end
            default: state_d = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            state_q <= FR_IDLE;
            rem_q   <= '0;
            sz_q    <= '0;
            vc_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sz_q    <= sz_d;
            vc_q    <= vc_d;
        end
    end

    pkt_tx_out_reg #(
        .Width(OutW)
    ) u_out_reg (
        .clk_i      (clk_axi),
        .rst_i      (arst_axi),
        .in_valid_i (wr_valid_i),
        .in_ready_o (wr_ready_o),
        .in_data_i  ({req_new_d, req_last_d, wr_data_i, out_sz_d, out_vc_d}),
        .out_valid_o(pkt_valid_o),
        .out_ready_i(pkt_ready_i),
        .out_data_o (out_payload)
    );

    assign {pkt_req_new_o, pkt_req_last_o, pkt_data_o, pkt_sz_o, pkt_vc_o} = out_payload;

`ifdef FRAMER_VC_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept && (state_q == FR_IN_PKT) && (wr_vc_i != vc_q)) err_d = 1'b1;
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_pkt_tx_framer.sv
// Scoreboard bench for pkt_tx_framer: the driver queues expected requests on accept,
// a negedge monitor pops and compares every transferred output.
module tb_pkt_tx_framer;
    logic        clk_axi = 1'b0;
    logic        arst_axi;
    logic        wr_valid_i, wr_ready_o;
    logic [31:0] wr_data_i;
    logic [0:0]  wr_vc_i;
    logic [7:0]  wr_pkt_sz_i;
    logic        pkt_valid_o, pkt_ready_i, pkt_req_new_o, pkt_req_last_o;
    logic [31:0] pkt_data_o;
    logic [7:0]  pkt_sz_o;
    logic [0:0]  pkt_vc_o;
    logic        busy_o, err_o;

    typedef struct packed {
        logic        n;
        logic        l;
        logic [31:0] d;
        logic [7:0]  sz;
        logic [0:0]  vc;
    } exp_t;

    exp_t sb[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   out_cnt  = 0;

    always #5 clk_axi = ~clk_axi;

    pkt_tx_framer dut (
        .clk_axi       (clk_axi),
        .arst_axi      (arst_axi),
        .wr_valid_i    (wr_valid_i),
        .wr_ready_o    (wr_ready_o),
        .wr_data_i     (wr_data_i),
        .wr_vc_i       (wr_vc_i),
        .wr_pkt_sz_i   (wr_pkt_sz_i),
        .pkt_valid_o   (pkt_valid_o),
        .pkt_ready_i   (pkt_ready_i),
        .pkt_req_new_o (pkt_req_new_o),
        .pkt_req_last_o(pkt_req_last_o),
        .pkt_data_o    (pkt_data_o),
        .pkt_sz_o      (pkt_sz_o),
        .pkt_vc_o      (pkt_vc_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pop on each transfer, and require held outputs during a stall.
    initial begin
        exp_t cur, held, e;
        bit   prev_stall = 1'b0;
        forever begin
            @(negedge clk_axi);
            cur = '{pkt_req_new_o, pkt_req_last_o, pkt_data_o, pkt_sz_o, pkt_vc_o};
            if (!arst_axi) begin
                if (prev_stall) begin
                    check("stall_valid_held", 64'(pkt_valid_o), 64'(1));
                    check("stall_fields_held", 64'(cur), 64'(held));
                end
                if (pkt_valid_o && pkt_ready_i) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 64'(cur), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        check("out_beat", 64'(cur), 64'(e));
                        out_cnt++;
                    end
                end
            end
            prev_stall = pkt_valid_o && !pkt_ready_i && !arst_axi;
            held       = cur;
        end
    end

    task automatic send(input logic [31:0] d, input logic vc, input logic [7:0] sz,
                        input logic en, input logic el, input logic [7:0] esz,
                        input logic evc, input logic eb);
        int t = 0;
        wr_valid_i  = 1'b1;
        wr_data_i   = d;
        wr_vc_i     = vc;
        wr_pkt_sz_i = sz;
        forever begin
            @(negedge clk_axi);
            if (wr_ready_o) break;
            t++;
            if (t > 200) begin
                check("accept_timeout", 64'(0), 64'(1));
                break;
            end
        end
        @(posedge clk_axi);
        sb.push_back('{en, el, d, esz, evc});
        #1;
        wr_valid_i = 1'b0;
        check("busy_after_beat", 64'(busy_o), 64'(eb));
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(posedge clk_axi);
            t++;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
        @(posedge clk_axi);
        #1;
    endtask

    initial begin
        int   base;
        exp_t dropped;
        arst_axi    = 1'b1;
        wr_valid_i  = 1'b0;
        wr_data_i   = '0;
        wr_vc_i     = '0;
        wr_pkt_sz_i = '0;
        pkt_ready_i = 1'b1;
        #1;
        check("rst_valid", 64'(pkt_valid_o), 64'(0));
        check("rst_fields", 64'({pkt_req_new_o, pkt_req_last_o, pkt_data_o, pkt_sz_o, pkt_vc_o}), 64'(0));
        check("rst_busy_err", 64'({busy_o, err_o}), 64'(0));
        check("rst_wr_ready", 64'(wr_ready_o), 64'(1));
        repeat (2) @(posedge clk_axi);
        #1 arst_axi = 1'b0;

        // 1: single-flit packet
        send(32'hA5A5A5A5, 1'b1, 8'd0, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0);
        drain();

        // 2: four-flit packet, back to back
        send(32'h1111_0000, 1'b0, 8'd3, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1);
        send(32'h1111_0001, 1'b0, 8'd7, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1);
        send(32'h1111_0002, 1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1);
        send(32'h1111_0003, 1'b0, 8'd0, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
        drain();

        // 3: same packet with a 5-cycle downstream stall after the 2nd output
        base = out_cnt;
        fork
            begin
                send(32'h3000_0000, 1'b0, 8'd3, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1);
                send(32'h3000_0001, 1'b0, 8'd3, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1);
                send(32'h3000_0002, 1'b0, 8'd3, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1);
                send(32'h3000_0003, 1'b0, 8'd3, 1'b0, 1'b1, 8'd3, 1'b0, 1'b0);
            end
            begin
                int t = 0;
                while (out_cnt < base + 2 && t < 200) begin
                    @(posedge clk_axi);
                    t++;
                end
                #1 pkt_ready_i = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk_axi);
                    check("stall_wr_ready", 64'({wr_ready_o, pkt_valid_o}), 64'(2'b01));
                end
                @(posedge clk_axi);
                #1 pkt_ready_i = 1'b1;
            end
        join
        drain();
        check("err_before_mismatch", 64'(err_o), 64'(0));

        // 4: body beats on the wrong VC still go out on the head's VC
        send(32'h4000_0000, 1'b1, 8'd2, 1'b1, 1'b0, 8'd2, 1'b1, 1'b1);
        send(32'h4000_0001, 1'b0, 8'd0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1);
        send(32'h4000_0002, 1'b0, 8'd0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0);
        drain();
`ifdef FRAMER_VC_CHECK_EN
        check("err_vc_mismatch", 64'(err_o), 64'(1));
`else
        check("err_vc_mismatch", 64'(err_o), 64'(0));
`endif

        // 5: reset after 2 of 5 flits, with the 2nd flit still held in the slot
        send(32'h5000_0000, 1'b0, 8'd4, 1'b1, 1'b0, 8'd4, 1'b0, 1'b1);
        send(32'h5000_0001, 1'b0, 8'd0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1);
        pkt_ready_i = 1'b0;
        dropped = sb.pop_back();
        @(posedge clk_axi);
        #1;
        check("pre_rst_busy_valid", 64'({busy_o, pkt_valid_o}), 64'(2'b11));
        arst_axi = 1'b1;
        #1;
        check("midrst_valid", 64'(pkt_valid_o), 64'(0));
        check("midrst_fields", 64'({pkt_req_new_o, pkt_req_last_o, pkt_data_o, pkt_sz_o, pkt_vc_o}), 64'(0));
        check("midrst_busy_err", 64'({busy_o, err_o}), 64'(0));
        @(posedge clk_axi);
        #1;
        arst_axi    = 1'b0;
        pkt_ready_i = 1'b1;
        send(32'h5500_0000, 1'b1, 8'd1, 1'b1, 1'b0, 8'd1, 1'b1, 1'b1);
        send(32'h5500_0001, 1'b0, 8'd9, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0);
        drain();
        check("dropped_beat_was_body", 64'(dropped.d), 64'(32'h5000_0001));

        // 6: maximum packet size, 256 flits
        for (int i = 0; i < 256; i++) begin
            send(32'(i) | 32'h6000_0000, 1'b0, 8'd255,
                 (i == 0), (i == 255), 8'd255, 1'b0, (i != 255));
        end
        drain();
        check("max_rem_zero", 64'(dut.rem_q), 64'(0));
        check("max_busy_idle", 64'(busy_o), 64'(0));
        send(32'h7777_7777, 1'b0, 8'd0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
